// File: rtl/tdc_reader_pkg.sv
// Shared types and constants for the TDC event reader.
package tdc_reader_pkg;

   localparam int          DEF_CHAN_W = 2;
   localparam int          DEF_TS_W   = 32;
   localparam logic [15:0] STALL_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      CAPTURE = 2'd1,
      CLEAR   = 2'd2
   } reader_state_e;

   // Default record layout; the top builds its own with the configured widths.
   typedef struct packed {
      logic [DEF_CHAN_W-1:0] chan;
      logic [DEF_TS_W-1:0]   timestamp;
      logic [DEF_TS_W-1:0]   width;
   } tdc_record_t;

endpackage

// File: rtl/tdc_record_fifo.sv
// First-word-fall-through record FIFO. Head entry is visible on dout while
// not empty; dout is forced to zero when empty so the outputs read as
// zero after reset. Push is refused when full, pop is refused when empty.
module tdc_record_fifo
   import tdc_reader_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type rec_t = tdc_record_t
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  rec_t                     din,
   input  logic                     pop,
   output rec_t                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_LVL);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign level   = count;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tdc_event_reader.sv
// Round-robin reader for a bank of TDC channels. Each pending event is
// captured (SCAN -> CAPTURE), acknowledged with a one-cycle clear
// (CLEAR), and queued as {chan, timestamp, width} in an FWFT FIFO.
// The CLEAR guard cycle lets the channel drop hasEvent before it can be
// examined again, so a single event is never captured twice.
module tdc_event_reader
   import tdc_reader_pkg::*;
#(
   parameter  int NUM_CHAN   = 4,
   parameter  int TS_WIDTH   = 32,
   parameter  int FIFO_DEPTH = 4,
   localparam int CHAN_W     = $clog2(NUM_CHAN)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_CHAN-1:0]           chan_has_event,
   input  logic [NUM_CHAN*TS_WIDTH-1:0]  chan_timestamp,
   input  logic [NUM_CHAN*TS_WIDTH-1:0]  chan_tot,
   output logic [NUM_CHAN-1:0]           chan_clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHAN_W-1:0]             out_chan,
   output logic [TS_WIDTH-1:0]           out_timestamp,
   output logic [TS_WIDTH-1:0]           out_width,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   stall_count
);

   typedef struct packed {
      logic [CHAN_W-1:0]   chan;
      logic [TS_WIDTH-1:0] timestamp;
      logic [TS_WIDTH-1:0] width;
   } rec_t;

   // Modular pulse width; a counter wrap between edges still yields the true width.
   function automatic logic [TS_WIDTH-1:0] pulse_width(input logic [TS_WIDTH-1:0] ts,
                                                       input logic [TS_WIDTH-1:0] tot);
      return tot - ts;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == STALL_MAX) ? v : v + 16'd1;
   endfunction

   function automatic logic [CHAN_W-1:0] ptr_next(input logic [CHAN_W-1:0] p);
      return (p == CHAN_W'(NUM_CHAN-1)) ? '0 : p + 1'b1;
   endfunction

   reader_state_e       state;
   reader_state_e       state_nxt;
   logic [CHAN_W-1:0]   ptr;
   logic [CHAN_W-1:0]   ptr_nxt;
   logic [NUM_CHAN-1:0] clear_nxt;
   logic [15:0]         stall_nxt;
   logic                push;
   logic                fifo_full;
   logic                fifo_empty;
   rec_t                rec_in;
   rec_t                rec_head;
   logic [TS_WIDTH-1:0] ts_arr  [NUM_CHAN];
   logic [TS_WIDTH-1:0] tot_arr [NUM_CHAN];

   // Unpack the per-channel timestamp buses.
   always_comb begin
      for (int i = 0; i < NUM_CHAN; i++) begin
         ts_arr[i]  = chan_timestamp[i*TS_WIDTH +: TS_WIDTH];
         tot_arr[i] = chan_tot[i*TS_WIDTH +: TS_WIDTH];
      end
   end

   // Record for the channel under the scan pointer.
   always_comb begin
      rec_in           = '0;
      rec_in.chan      = ptr;
      rec_in.timestamp = ts_arr[ptr];
      rec_in.width     = pulse_width(ts_arr[ptr], tot_arr[ptr]);
   end

   // Next-state, pointer, clear and stall logic.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      clear_nxt = '0;
      stall_nxt = stall_count;
      push      = 1'b0;
      unique case (state)
         SCAN: begin
            if (enable && chan_has_event[ptr]) begin
               // Full flag is the pre-pop value; a blocked channel holds the pointer.
               if (!fifo_full) state_nxt = CAPTURE;
               else            stall_nxt = sat_inc(stall_count);
            end else begin
               ptr_nxt = ptr_next(ptr);
            end
         end
         CAPTURE: begin
            push      = 1'b1;
            clear_nxt = NUM_CHAN'(1) << ptr;
            state_nxt = CLEAR;
         end
         CLEAR: begin
            ptr_nxt   = ptr_next(ptr);
            state_nxt = SCAN;
         end
         default: state_nxt = SCAN;
      endcase
   end

   // Control registers; reset aborts any in-flight clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SCAN;
         ptr         <= '0;
         chan_clear  <= '0;
         stall_count <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         chan_clear  <= clear_nxt;
         stall_count <= stall_nxt;
      end
   end

   tdc_record_fifo #(
      .DEPTH (FIFO_DEPTH),
      .rec_t (rec_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (rec_in),
      .pop   (out_valid & out_ready),
      .dout  (rec_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign out_valid     = ~fifo_empty;
   assign out_chan      = rec_head.chan;
   assign out_timestamp = rec_head.timestamp;
   assign out_width     = rec_head.width;

endmodule
